// File: rtl/sha256_block_engine.sv
// sha256_block_engine: iterative SHA-256 compression, one round per clock, H chained across blocks.
// Define SHA256_SHA224_EN to add the s_sha224 input (SHA-224 IV and truncated digest).
module sha256_block_engine (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         s_first,
`ifdef SHA256_SHA224_EN
   input  logic         s_sha224,
`endif
   input  logic [511:0] s_block,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [255:0] m_digest,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
   localparam logic [7:0][31:0] IV256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   function automatic logic [31:0] e0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction
   function automatic logic [31:0] e1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction
   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction
   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction
   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction
   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction
   state_t            r_state;
   logic [5:0]        r_t;
   logic              r_first;
   logic              r_s_ready;
   logic              r_m_valid;
   logic              r_busy;
   logic [255:0]      r_digest;
   // Word index 7 is H0/a, index 0 is H7/h; window index 15 holds W_t, index 0 holds W_t+15.
   logic [7:0][31:0]  r_h;
   logic [7:0][31:0]  r_v;
   logic [15:0][31:0] r_w;
   logic [7:0][31:0]  w_hn;
   logic [7:0][31:0]  w_iv_acc;
   logic [7:0][31:0]  w_base;
   logic [255:0]      w_digest;
   logic [31:0]       w_t1;
   logic [31:0]       w_t2;
   logic [31:0]       w_wn;
`ifdef SHA256_SHA224_EN
   localparam logic [7:0][31:0] IV224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   logic r_224;
   assign w_iv_acc = s_sha224 ? IV224 : IV256;
   assign w_base   = r_first ? (r_224 ? IV224 : IV256) : r_h;
   assign w_digest = {w_hn[7:1], r_224 ? 32'h0 : w_hn[0]};
`else
   assign w_iv_acc = IV256;
   assign w_base   = r_first ? IV256 : r_h;
   assign w_digest = w_hn;
`endif
   assign w_t1 = r_v[0] + e1(r_v[3]) + ch(r_v[3], r_v[2], r_v[1]) + K[r_t] + r_w[15];
   assign w_t2 = e0(r_v[7]) + maj(r_v[7], r_v[6], r_v[5]);
   assign w_wn = s1(r_w[1]) + r_w[6] + s0(r_w[14]) + r_w[15];
   always_comb begin
      w_hn = '0;
      for (int i = 0; i < 8; i++) w_hn[i] = w_base[i] + r_v[i];
   end
   assign s_ready  = r_s_ready;
   assign m_valid  = r_m_valid;
   assign m_digest = r_digest;
   assign busy     = r_busy;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_t       <= '0;
         r_first   <= 1'b0;
`ifdef SHA256_SHA224_EN
         r_224     <= 1'b0;
`endif
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_digest  <= '0;
         r_h       <= IV256;
         r_v       <= '0;
         r_w       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_s_ready <= 1'b1;
               if (s_valid && r_s_ready) begin
                  r_w       <= s_block;
                  r_v       <= s_first ? w_iv_acc : r_h;
                  r_t       <= '0;
                  r_first   <= s_first;
`ifdef SHA256_SHA224_EN
                  r_224     <= s_sha224;
`endif
                  r_s_ready <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ROUND;
               end
            end
            ROUND: begin
               r_v <= {w_t1 + w_t2, r_v[7:5], r_v[4] + w_t1, r_v[3:1]};
               r_w <= {r_w[14:0], w_wn};
               r_t <= r_t + 6'd1;
               if (r_t == 6'd63) r_state <= FINAL;
            end
            FINAL: begin
               r_h       <= w_hn;
               r_digest  <= w_digest;
               r_m_valid <= 1'b1;
               r_state   <= DONE;
            end
            DONE: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_block_engine.sv
// tb_sha256_block_engine: directed known-answer tests for the SHA-256 block engine.
module tb_sha256_block_engine;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_first = 1'b0;
   logic         m_ready = 1'b0;
   logic [511:0] s_block = '0;
   logic         s_ready;
   logic         m_valid;
   logic         busy;
   logic [255:0] m_digest;
`ifdef SHA256_SHA224_EN
   logic         s_sha224 = 1'b0;
`endif
   int n_checks = 0;
   int n_fail = 0;
   localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO2  = {480'h0, 32'h000001c0};
   localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   always #5 clk = ~clk;
   sha256_block_engine dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first),
`ifdef SHA256_SHA224_EN
      .s_sha224(s_sha224),
`endif
      .s_block(s_block), .m_valid(m_valid), .m_ready(m_ready), .m_digest(m_digest), .busy(busy));
   // Offers one block, then counts falling edges from the accept edge until m_valid (200 = timeout).
   task automatic run_block(input logic first, input logic [511:0] blk, output logic rdy, output int lat);
      @(negedge clk);
      rdy = s_ready;
      s_valid = 1'b1;
      s_first = first;
      s_block = blk;
      @(negedge clk);
      s_valid = 1'b0;
      lat = 0;
      while (!m_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic handshake();
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask
   task automatic test_reset();
      #2;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_checks++; if (m_digest !== 256'h0) begin n_fail++; $display("FAIL rst_digest: got %h expected 0", m_digest); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); end
   endtask
   task automatic test_abc();
      logic rdy;
      int lat;
      run_block(1'b1, ABC, rdy, lat);
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL abc_ready: got %b expected 1", rdy); end
      n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abc_latency: got %0d expected 65", lat); end
      n_checks++; if (m_digest !== ABC_D) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", m_digest, ABC_D); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abc_busy: got %b expected 1", busy); end
      handshake();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abc_hs_m_valid: got %b expected 0", m_valid); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL abc_hs_s_ready: got %b expected 1", s_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_hs_busy: got %b expected 0", busy); end
   endtask
   task automatic test_empty();
      logic rdy;
      int lat;
      run_block(1'b1, EMPTY, rdy, lat);
      n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL empty_latency: got %0d expected 65", lat); end
      n_checks++; if (m_digest !== EMPTY_D) begin n_fail++; $display("FAIL empty_digest: got %h expected %h", m_digest, EMPTY_D); end
      handshake();
   endtask
   task automatic test_two_block();
      logic rdy;
      int lat;
      run_block(1'b1, TWO1, rdy, lat);
      n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL two_blk1_latency: got %0d expected 65", lat); end
      handshake();
      run_block(1'b0, TWO2, rdy, lat);
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL two_blk2_ready: got %b expected 1", rdy); end
      n_checks++; if (m_digest !== TWO_D) begin n_fail++; $display("FAIL two_digest: got %h expected %h", m_digest, TWO_D); end
      handshake();
   endtask
   task automatic test_backpressure();
      logic rdy;
      int lat;
      run_block(1'b1, ABC, rdy, lat);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin s_valid = 1'b1; s_first = 1'b1; s_block = EMPTY; end
         if (i == 10) s_valid = 1'b0;
         @(negedge clk);
         n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid[%0d]: got %b expected 1", i, m_valid); end
         n_checks++; if (m_digest !== ABC_D) begin n_fail++; $display("FAIL bp_digest[%0d]: got %h expected %h", i, m_digest, ABC_D); end
         n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d]: got %b expected 0", i, s_ready); end
      end
      handshake();
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_hs_s_ready: got %b expected 1", s_ready); end
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_block: busy %b expected 0", busy); end
   endtask
   task automatic test_reset_abort();
      logic rdy;
      int lat;
      int hits;
      @(negedge clk);
      s_valid = 1'b1;
      s_first = 1'b1;
      s_block = ABC;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (30) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL abort_s_ready: got %b expected 0", s_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_valid) hits++;
      end
      n_checks++; if (hits !== 0) begin n_fail++; $display("FAIL abort_no_digest: m_valid cycles %0d expected 0", hits); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_s_ready_after: got %b expected 1", s_ready); end
      n_checks++; if (m_digest !== 256'h0) begin n_fail++; $display("FAIL abort_digest_cleared: got %h expected 0", m_digest); end
      run_block(1'b0, ABC, rdy, lat);
      n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d expected 65", lat); end
      n_checks++; if (m_digest !== ABC_D) begin n_fail++; $display("FAIL abort_rerun_digest: got %h expected %h", m_digest, ABC_D); end
      handshake();
   endtask
   task automatic test_back_to_back();
      int hits;
      hits = 0;
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_first = 1'b1;
      s_block = EMPTY;
      for (int n = 0; n <= 140; n++) begin
         @(negedge clk);
         if (n == 67) s_valid = 1'b0;
         if (m_valid) hits++;
         if (n == 65) begin
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b expected 1", m_valid); end
            n_checks++; if (m_digest !== EMPTY_D) begin n_fail++; $display("FAIL b2b_first_digest: got %h expected %h", m_digest, EMPTY_D); end
         end
         if (n == 66) begin
            n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_s_ready: got %b expected 1", s_ready); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
         end
         if (n == 67) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy %b expected 1", busy); end
         end
         if (n == 132) begin
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b expected 1", m_valid); end
            n_checks++; if (m_digest !== EMPTY_D) begin n_fail++; $display("FAIL b2b_second_digest: got %h expected %h", m_digest, EMPTY_D); end
         end
      end
      m_ready = 1'b0;
      n_checks++; if (hits !== 2) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d expected 2", hits); end
   endtask
`ifdef SHA256_SHA224_EN
   task automatic test_sha224();
      logic rdy;
      int lat;
      s_sha224 = 1'b1;
      run_block(1'b1, ABC, rdy, lat);
      s_sha224 = 1'b0;
      n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL sha224_latency: got %0d expected 65", lat); end
      n_checks++; if (m_digest !== 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000) begin
         n_fail++; $display("FAIL sha224_digest: got %h expected 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000", m_digest);
      end
      handshake();
   endtask
`endif
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_two_block();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
`ifdef SHA256_SHA224_EN
      test_sha224();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
